regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised general-purpose register file: two combinational read ports, one byte-enabled write port.
- Adds a per-register pending-write scoreboard so the pipeline can detect RAW hazards.
- Register 0 is optionally hardwired to zero.
- Sits between decode (read/issue) and writeback (write/clear) in the single-issue core datapath.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; 2..64, not required to be a power of 2.
- ZERO_X0, 1, when 1 register 0 reads as 0, ignores writes and is never marked busy.
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  WIDTH  read port 1 data (combinational).
- rs2_data  out  WIDTH  read port 2 data (combinational).
- rs1_busy  out  1  register at rs1_addr has a pending write.
- rs2_busy  out  1  register at rs2_addr has a pending write.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback address.
- wr_be  in  WIDTH/8  byte enables for the write.
- wr_data  in  WIDTH  writeback data.
- issue_en  in  1  an instruction with a destination issues this cycle.
- issue_rd  in  AW  destination register of the issuing instruction.
- flush  in  1  clears every busy bit (pipeline squash).
- busy_vec  out  DEPTH  registered scoreboard, bit i = register i pending.

Behaviour:
- Reset:
  - rst low clears all registers and busy bits to 0 immediately, regardless of clk.
  - All outputs read 0 while rst is low.
  - Reset mid-write: the write is discarded.
- Write:
  - On the rising edge with wr_en=1 and wr_addr<DEPTH, byte k of reg[wr_addr] takes wr_data byte k where wr_be[k]=1; other bytes are held.
  - wr_addr>=DEPTH: no state change.
  - With ZERO_X0=1, writes to address 0 are dropped.
- Read:
  - rsN_data = reg[rsN_addr], combinational.
  - Address >= DEPTH returns 0.
  - With ZERO_X0=1, address 0 returns 0.
- Scoreboard (busy[i] per register, reset 0); next-state priority, highest first:
  1. flush=1: all busy bits become 0; issue_en ignored that cycle.
  2. issue_en=1, issue_rd valid and not (ZERO_X0 and issue_rd=0): busy[issue_rd] set to 1.
  3. wr_en=1, wr_addr valid: busy[wr_addr] cleared to 0.
- Issue and writeback to the same address in one cycle: set wins (new producer), so the bit stays 1.
- Issue to an already-busy register: the bit remains 1. No counting; single outstanding producer per register is assumed by the pipeline.
- rsN_busy = busy[rsN_addr], 0 for invalid addresses or hardwired x0.
- busy_vec is the raw registered scoreboard.
- Latency: writes visible on read ports one cycle after the write edge; busy set or clear visible one cycle after the edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle write-through. If wr_en=1 and wr_addr==rsN_addr (valid, not hardwired x0), rsN_data returns stored data with enabled bytes replaced by wr_data.
  - rsN_busy is forced 0 for that address in that cycle.
  - Zero read latency for writeback-to-decode.
- Undefined:
  - Reads return the pre-edge stored value.
  - rsN_busy reflects the registered bit only.
  - Decode must stall one extra cycle.

Decomposition:
- Shared package core_pkg holds:
  - REG_WIDTH=32, REG_DEPTH=32 and REG_AW.
  - The reg-address type.
  - Localparam X0_ADDR=0.
- One sub-module is natural: regfile_busy_tracker, holding the DEPTH-bit scoreboard with the flush/issue/clear priority logic.
- The storage array and read muxing stay in the top module.

Test Plan:
- Reset: drive rst low mid-cycle after writing reg5=0xDEADBEEF -> rs1_data(addr5)=0 and busy_vec=0 immediately, without waiting for a clock edge.
- Byte enables: write reg3=0x11223344 with be=1111, then 0xAABBCCDD with be=0101 -> reg3 reads 0x11BB33DD.
- x0: write 0xFFFFFFFF to reg0 and issue rd=0 -> rs1_data=0, rs1_busy=0, busy_vec[0]=0. With ZERO_X0=0 -> reads 0xFFFFFFFF.
- Scoreboard collision: issue rd=7, then next cycle wr_en to reg7 together with issue rd=7 -> busy_vec[7] stays 1. Plain writeback the cycle after -> 0.
- Flush: set busy on regs 2, 4 and 9; assert flush together with issue rd=10 -> busy_vec=0 on the next cycle.
- Bypass: wr_en to reg12=0xCAFEF00D with rs2_addr=12 in the same cycle.
  - With REGFILE_BYPASS_EN: rs2_data=0xCAFEF00D and rs2_busy=0 in that cycle.
  - Without it: old value in that cycle, new value next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared register-file sizing, address type and slot helper
package core_pkg;

    localparam int REG_WIDTH = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = $clog2(REG_DEPTH);
    localparam int X0_ADDR   = 0;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // True when addr names a real, writable register (inside the array and not a hardwired x0)
    function automatic logic slot_ok(input int addr, input int depth, input int zero_x0);
        return (addr < depth) && !((zero_x0 != 0) && (addr == X0_ADDR));
    endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// rtl/regfile_busy_tracker.sv - per-register pending-write scoreboard with flush/issue/clear priority
module regfile_busy_tracker
    import core_pkg::*;
#(
    parameter  int DEPTH   = REG_DEPTH,
    parameter  int ZERO_X0 = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    output logic [DEPTH-1:0] busy_vec
);

    logic [DEPTH-1:0] busy_nxt;

    // Next scoreboard: flush beats everything, a new producer beats a retiring one
    always_comb begin
        busy_nxt = busy_vec;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_en && (issue_rd == AW'(i)) && slot_ok(i, DEPTH, ZERO_X0)) begin
                    busy_nxt[i] = 1'b1;
                end else if (wr_en && (wr_addr == AW'(i))) begin
                    busy_nxt[i] = 1'b0;
                end
            end
        end
    end

    // Scoreboard register, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R/1W byte-enabled register file with RAW scoreboard (optional REGFILE_BYPASS_EN write-through)
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter  int WIDTH   = REG_WIDTH,
    parameter  int DEPTH   = REG_DEPTH,
    parameter  int ZERO_X0 = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        rs1_addr,
    input  logic [AW-1:0]        rs2_addr,
    output logic [WIDTH-1:0]     rs1_data,
    output logic [WIDTH-1:0]     rs2_data,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH/8-1:0]   wr_be,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 flush,
    output logic [DEPTH-1:0]     busy_vec
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0]           mem [DEPTH];
    logic                       wr_ok;
    logic [1:0][AW-1:0]         rd_addr;
    logic [1:0][WIDTH-1:0]      rd_data;
    logic [1:0]                 rd_busy;

    assign wr_ok      = wr_en && slot_ok(int'(wr_addr), DEPTH, ZERO_X0);
    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;
    assign rs1_data   = rd_data[0];
    assign rs2_data   = rd_data[1];
    assign rs1_busy   = rd_busy[0];
    assign rs2_busy   = rd_busy[1];

    regfile_busy_tracker #(
        .DEPTH   (DEPTH),
        .ZERO_X0 (ZERO_X0)
    ) u_busy (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

    // Storage: byte-masked writeback; an edge arriving while reset is low discards the write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) begin
                    mem[wr_addr][k*8 +: 8] <= wr_data[k*8 +: 8];
                end
            end
        end
    end

    // Read muxes: out-of-range and hardwired x0 read as zero; everything is forced low during reset
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            if (rst && slot_ok(int'(rd_addr[p]), DEPTH, ZERO_X0)) begin
                rd_data[p] = mem[rd_addr[p]];
                rd_busy[p] = busy_vec[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (wr_addr == rd_addr[p])) begin
                    rd_busy[p] = 1'b0;
                    for (int k = 0; k < NB; k++) begin
                        if (wr_be[k]) begin
                            rd_data[p][k*8 +: 8] = wr_data[k*8 +: 8];
                        end
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized model-checked bench for regfile_scoreboard (x0 hardwired and plain, depth 32 and 20)
module tb_regfile_scoreboard;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    reg_addr_t   rs1_addr, rs2_addr, wr_addr, issue_rd;
    logic        wr_en, issue_en, flush;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    logic [31:0] rs1_data_a, rs2_data_a, rs1_data_b, rs2_data_b;
    logic        rs1_busy_a, rs2_busy_a, rs1_busy_b, rs2_busy_b;
    logic [31:0] busy_vec_a;
    logic [19:0] busy_vec_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ZERO_X0(1)) dut_a (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_a), .rs2_data(rs2_data_a), .rs1_busy(rs1_busy_a), .rs2_busy(rs2_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .busy_vec(busy_vec_a)
    );

    regfile_scoreboard #(.WIDTH(32), .DEPTH(20), .ZERO_X0(0)) dut_b (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_b), .rs2_data(rs2_data_b), .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .busy_vec(busy_vec_b)
    );

    // Reference model: instance 0 = depth 32 with x0 hardwired, instance 1 = depth 20 plain
    int unsigned mem_m  [2][64];
    bit          busy_m [2][64];
    int          depth_m [2] = '{32, 20};
    int          zx_m    [2] = '{1, 0};

    function automatic bit ok_m(int inst, int a);
        return (a < depth_m[inst]) && !(zx_m[inst] == 1 && a == 0);
    endfunction

    function automatic logic [31:0] byte_mask(logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] merged(logic [31:0] old);
        return (old & ~byte_mask(wr_be)) | (wr_data & byte_mask(wr_be));
    endfunction

    function automatic logic [31:0] exp_data(int inst, int a);
        logic [31:0] v;
        if (!rst || !ok_m(inst, a)) return 32'h0;
        v = mem_m[inst][a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && int'(wr_addr) == a) v = merged(v);
`endif
        return v;
    endfunction

    function automatic logic exp_busy(int inst, int a);
        if (!rst || !ok_m(inst, a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && int'(wr_addr) == a) return 1'b0;
`endif
        return busy_m[inst][a];
    endfunction

    function automatic logic [63:0] exp_vec(int inst);
        logic [63:0] v = '0;
        for (int i = 0; i < depth_m[inst]; i++) v[i] = busy_m[inst][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < 64; i++) begin
                mem_m[n][i]  = 0;
                busy_m[n][i] = 0;
            end
    endtask

    task automatic model_clock();
        for (int n = 0; n < 2; n++) begin
            if (wr_en && ok_m(n, int'(wr_addr))) begin
                mem_m[n][wr_addr]  = merged(mem_m[n][wr_addr]);
                busy_m[n][wr_addr] = 0;
            end
            if (flush) begin
                for (int i = 0; i < 64; i++) busy_m[n][i] = 0;
            end else if (issue_en && ok_m(n, int'(issue_rd))) begin
                busy_m[n][issue_rd] = 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("a_rs1_data", 64'(rs1_data_a), 64'(exp_data(0, int'(rs1_addr))));
        check("a_rs2_data", 64'(rs2_data_a), 64'(exp_data(0, int'(rs2_addr))));
        check("a_rs1_busy", 64'(rs1_busy_a), 64'(exp_busy(0, int'(rs1_addr))));
        check("a_rs2_busy", 64'(rs2_busy_a), 64'(exp_busy(0, int'(rs2_addr))));
        check("a_busy_vec", 64'(busy_vec_a), exp_vec(0));
        check("b_rs1_data", 64'(rs1_data_b), 64'(exp_data(1, int'(rs1_addr))));
        check("b_rs2_data", 64'(rs2_data_b), 64'(exp_data(1, int'(rs2_addr))));
        check("b_rs1_busy", 64'(rs1_busy_b), 64'(exp_busy(1, int'(rs1_addr))));
        check("b_rs2_busy", 64'(rs2_busy_b), 64'(exp_busy(1, int'(rs2_addr))));
        check("b_busy_vec", 64'(busy_vec_b), exp_vec(1));
    endtask

    // Inputs are driven at the falling edge; outputs checked 1 time unit later, model advanced at the rising edge
    task automatic tick();
        #1 check_outputs();
        @(posedge clk);
        if (rst) model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 0; issue_en = 0; flush = 0;
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1; wr_addr = reg_addr_t'(a); wr_data = d; wr_be = be;
    endtask

    task automatic do_issue(input int a);
        issue_en = 1; issue_rd = reg_addr_t'(a);
    endtask

    initial begin
        rst = 0; idle();
        rs1_addr = '0; rs2_addr = '0; wr_addr = '0; issue_rd = '0; wr_be = '0; wr_data = '0;
        model_reset();
        @(negedge clk);
        #1 check_outputs();
        rst = 1;
        @(negedge clk);

        // Byte enables
        do_write(3, 32'h11223344, 4'b1111); tick();
        do_write(3, 32'hAABBCCDD, 4'b0101); tick();
        idle(); rs1_addr = 3;
        #1 check("be_merge", 64'(rs1_data_a), 64'h11BB33DD);
        tick();

        // Hardwired x0 versus plain x0
        do_write(0, 32'hFFFFFFFF, 4'b1111); do_issue(0); tick();
        idle(); rs1_addr = 0;
        #1;
        check("x0_data", 64'(rs1_data_a), 64'h0);
        check("x0_busy", 64'(rs1_busy_a), 64'h0);
        check("x0_vec0", 64'(busy_vec_a[0]), 64'h0);
        check("x0_plain", 64'(rs1_data_b), 64'hFFFFFFFF);
        tick();

        // Issue/writeback collision on reg7
        do_issue(7); tick();
        do_write(7, 32'h00000777, 4'b1111); do_issue(7); tick();
        idle(); rs1_addr = 7;
        #1 check("collide_set", 64'(busy_vec_a[7]), 64'h1);
        do_write(7, 32'h00000778, 4'b1111); tick();
        idle();
        #1 check("collide_clr", 64'(busy_vec_a[7]), 64'h0);
        tick();

        // Flush beats a simultaneous issue
        do_issue(2); tick();
        do_issue(4); tick();
        do_issue(9); tick();
        idle();
        #1 check("pre_flush", 64'(busy_vec_a), 64'h214);
        flush = 1; do_issue(10); tick();
        idle();
        #1 check("flush_vec", 64'(busy_vec_a), 64'h0);
        tick();

        // Same-cycle write versus read of reg12
        do_issue(12); tick();
        idle(); do_write(12, 32'hCAFEF00D, 4'b1111); rs2_addr = 12;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_data", 64'(rs2_data_a), 64'hCAFEF00D);
        check("byp_busy", 64'(rs2_busy_a), 64'h0);
`else
        check("byp_data", 64'(rs2_data_a), 64'h0);
        check("byp_busy", 64'(rs2_busy_a), 64'h1);
`endif
        tick();
        idle();
        #1;
        check("byp_next", 64'(rs2_data_a), 64'hCAFEF00D);
        check("byp_nbusy", 64'(rs2_busy_a), 64'h0);
        tick();

        // Random traffic across both instances (addresses 20..31 are out of range for the depth-20 one)
        for (int c = 0; c < 400; c++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = reg_addr_t'($urandom_range(0, 31));
            wr_be    = 4'($urandom);
            wr_data  = $urandom;
            issue_en = ($urandom_range(0, 9) < 4);
            issue_rd = reg_addr_t'($urandom_range(0, 31));
            flush    = ($urandom_range(0, 15) == 0);
            rs1_addr = reg_addr_t'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 3) == 0) ? wr_addr : reg_addr_t'($urandom_range(0, 31));
            tick();
        end

        // Asynchronous reset mid-cycle, with a write pending across the next edge
        idle(); do_write(5, 32'hDEADBEEF, 4'b1111); do_issue(5); tick();
        idle(); rs1_addr = 5; do_write(6, 32'h12345678, 4'b1111);
        #1 check_outputs();
        #1 rst = 0;
        model_reset();
        #1;
        check("rst_data", 64'(rs1_data_a), 64'h0);
        check("rst_vec", 64'(busy_vec_a), 64'h0);
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1; idle(); rs1_addr = 6;
        #1 check("rst_drop", 64'(rs1_data_a), 64'h0);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
